// File: rtl/cic_integrator_cascade.sv
// CIC integrator cascade with an integrated output decimator.
// ORDER integrator stages are chained through a valid pipeline, so each stage
// updates only when the sample from the stage before it is valid. A ratio-driven
// counter picks every R-th result from the last stage as the decimated output.
module cic_integrator_cascade #(
    parameter int WIDTH_IN  = 9,
    parameter int WIDTH_OUT = 18,
    parameter int ORDER     = 3,
    parameter int SIGNED_IN = 0,
    parameter int RATIO_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH_IN-1:0]  data_in,
    input  logic [RATIO_W-1:0]   ratio,
    output logic [WIDTH_OUT-1:0] data_out,
    output logic                 out_valid,
    output logic [WIDTH_OUT-1:0] dec_data,
    output logic                 dec_valid
);

    // Stage k (1-based) lives at index k-1.
    logic [WIDTH_OUT-1:0] acc_q [ORDER];
    logic [WIDTH_OUT-1:0] acc_d [ORDER];
    logic [ORDER-1:0]     v_q, v_d;
    logic [RATIO_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_OUT-1:0] dec_data_q, dec_data_d;
    logic                 dec_valid_q, dec_valid_d;

    logic [WIDTH_OUT-1:0] data_ext;
    logic [RATIO_W-1:0]   ratio_m1;
    logic                 fire;

    // Widen the input sample to the accumulator width.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path leaves a value unassigned and infers a latch.
        data_ext = (SIGNED_IN != 0) ? WIDTH_OUT'($signed(data_in))
                                    : WIDTH_OUT'(data_in);
    end

    // Integrator chain: each stage accumulates the previous stage's stored value.
    // Additions wrap modulo 2^WIDTH_OUT, which the comb section downstream relies on.
    always_comb begin
        acc_d = acc_q;
        v_d   = v_q;
        if (clr) begin
            for (int k = 0; k < ORDER; k++) acc_d[k] = '0;
            v_d = '0;
        end else begin
            v_d[0] = in_valid;
            if (in_valid) acc_d[0] = acc_q[0] + data_ext;
            for (int k = 1; k < ORDER; k++) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) acc_d[k] = acc_q[k] + acc_q[k-1];
            end
        end
    end

    // Ratios 0 and 1 both mean "every sample"; >= makes a shrinking ratio fire at once.
    always_comb begin
        ratio_m1 = (ratio == '0) ? '0 : ratio - RATIO_W'(1);
        fire     = v_q[ORDER-1] && (cnt_q >= ratio_m1);
    end

    // Decimation counter and held decimated sample.
    always_comb begin
        cnt_d       = cnt_q;
        dec_data_d  = dec_data_q;
        dec_valid_d = 1'b0;
        if (clr) begin
            cnt_d      = '0;
            dec_data_d = '0;
        end else if (fire) begin
            cnt_d       = '0;
            dec_data_d  = acc_q[ORDER-1];
            dec_valid_d = 1'b1;
        end else if (v_q[ORDER-1]) begin
            cnt_d = cnt_q + RATIO_W'(1);
        end
    end

    // State registers with synchronous active-low reset taking priority over clr.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples
        // the pre-edge value of the others regardless of statement order.
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
            v_q         <= '0;
            cnt_q       <= '0;
            dec_data_q  <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) acc_q[k] <= acc_d[k];
            v_q         <= v_d;
            cnt_q       <= cnt_d;
            dec_data_q  <= dec_data_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign data_out  = acc_q[ORDER-1];
    assign out_valid = v_q[ORDER-1];
    assign dec_data  = dec_data_q;
    assign dec_valid = dec_valid_q;

endmodule

// File: tb/tb_cic_integrator_cascade.sv
// Bench for cic_integrator_cascade: three instances (ORDER=3 default, ORDER=1
// 8-bit wrap/decimation, ORDER=1 signed) sharing one clock and reset.
module tb_cic_integrator_cascade;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ORDER=3 instance
    logic        o3_clr, o3_valid, o3_out_valid, o3_dec_valid;
    logic [8:0]  o3_data;
    logic [7:0]  o3_ratio;
    logic [17:0] o3_out, o3_dec;

    cic_integrator_cascade u_o3 (
        .clk(clk), .rst_n(rst_n), .clr(o3_clr), .in_valid(o3_valid),
        .data_in(o3_data), .ratio(o3_ratio), .data_out(o3_out),
        .out_valid(o3_out_valid), .dec_data(o3_dec), .dec_valid(o3_dec_valid)
    );

    // ORDER=1, 8-bit instance
    logic        w8_clr, w8_valid, w8_out_valid, w8_dec_valid;
    logic [7:0]  w8_data, w8_ratio, w8_out, w8_dec;

    cic_integrator_cascade #(.WIDTH_IN(8), .WIDTH_OUT(8), .ORDER(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .clr(w8_clr), .in_valid(w8_valid),
        .data_in(w8_data), .ratio(w8_ratio), .data_out(w8_out),
        .out_valid(w8_out_valid), .dec_data(w8_dec), .dec_valid(w8_dec_valid)
    );

    // ORDER=1, signed instance
    logic        s_clr, s_valid, s_out_valid, s_dec_valid;
    logic [8:0]  s_data;
    logic [7:0]  s_ratio;
    logic [17:0] s_out, s_dec;

    cic_integrator_cascade #(.ORDER(1), .SIGNED_IN(1)) u_s (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .in_valid(s_valid),
        .data_in(s_data), .ratio(s_ratio), .data_out(s_out),
        .out_valid(s_out_valid), .dec_data(s_dec), .dec_valid(s_dec_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for u_o3: per-sample cascaded running sums, with the cycle the
    // result is due on out_valid.
    typedef struct {
        logic [17:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [17:0] obs_q[$];
    logic [17:0] s_mod [3];

    task automatic step_o3(input logic v, input logic [8:0] d, input logic c, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        o3_valid = v;
        o3_data  = d;
        o3_clr   = c;
        rst_n    = !r;
        if (c || r) begin
            while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
            for (int k = 0; k < 3; k++) s_mod[k] = '0;
        end else if (v) begin
            s_mod[0] = s_mod[0] + 18'(d);
            s_mod[1] = s_mod[1] + s_mod[0];
            s_mod[2] = s_mod[2] + s_mod[1];
            e.data = s_mod[2];
            e.due  = cyc + 3;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain_o3();
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        check("o3_drain_left", sb_q.size(), 0);
    endtask

    task automatic check_seq(input string tag, input logic [17:0] exp[], input int n);
        check({tag, "_count"}, obs_q.size(), n);
        for (int i = 0; i < n && i < obs_q.size(); i++) check(tag, obs_q[i], exp[i]);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o3_out_valid) begin
            if (sb_q.size() == 0) begin
                check("o3_spurious_out_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("o3_data_out", o3_out, e.data);
                check("o3_latency_cycle", cyc, e.due);
                obs_q.push_back(o3_out);
            end
        end
    end

    // Decimated strobes from u_w8
    int         dq_cyc[$];
    logic [7:0] dq_data[$];

    always @(negedge clk) begin
        if (w8_dec_valid) begin
            dq_cyc.push_back(cyc);
            dq_data.push_back(w8_dec);
        end
    end

    logic [17:0] seq5[] = '{18'd1, 18'd4, 18'd10, 18'd20, 18'd35};
    logic [17:0] seq3[] = '{18'd1, 18'd4, 18'd10};
    int          exp_off[7] = '{5, 9, 13, 17, 19, 21, 23};
    int          exp_dat[7] = '{4, 8, 12, 16, 18, 20, 22};
    int          c0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        o3_clr = 0; o3_valid = 0; o3_data = '0; o3_ratio = 8'd1;
        w8_clr = 0; w8_valid = 0; w8_data = '0; w8_ratio = 8'd4;
        s_clr  = 0; s_valid  = 0; s_data  = '0; s_ratio  = 8'd0;
        for (int k = 0; k < 3; k++) s_mod[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_o3_data_out", o3_out, 0);
        check("rst_o3_out_valid", o3_out_valid, 0);
        check("rst_o3_dec_data", o3_dec, 0);
        check("rst_o3_dec_valid", o3_dec_valid, 0);
        check("rst_w8_data_out", w8_out, 0);
        check("rst_s_out_valid", s_out_valid, 0);

        // Continuous unit input: 1, 4, 10, 20, 35 after 3 cycles
        obs_q.delete();
        for (int i = 0; i < 5; i++) step_o3(1, 9'd1, 0, 0);
        step_o3(0, 9'd0, 0, 0);
        drain_o3();
        check_seq("o3_cont_seq", seq5, 5);
        check("o3_dec_r1_last", o3_dec, 18'd35);

        // Toggling valid: gaps propagate as gaps
        step_o3(0, 9'd0, 1, 0);
        obs_q.delete();
        for (int i = 0; i < 3; i++) begin
            step_o3(1, 9'd1, 0, 0);
            step_o3(0, 9'd0, 0, 0);
        end
        drain_o3();
        check_seq("o3_toggle_seq", seq3, 3);

        // 8-bit wrap: 255 + 255 -> 254
        @(posedge clk); #1;
        w8_valid = 1; w8_data = 8'd255;
        @(posedge clk); #1;
        check("w8_first", w8_out, 8'd255);
        check("w8_first_valid", w8_out_valid, 1);
        @(posedge clk); #1;
        w8_valid = 0;
        check("w8_wrap", w8_out, 8'd254);
        w8_clr = 1;
        @(posedge clk); #1;
        w8_clr = 0;
        check("w8_clr_data_out", w8_out, 0);

        // Signed extension, ratio 0 decimates by 1
        @(posedge clk); #1;
        s_valid = 1; s_data = 9'h1FF;
        @(posedge clk); #1;
        s_data = 9'h001;
        check("s_neg_one", s_out, 18'h3FFFF);
        check("s_neg_dec_valid_early", s_dec_valid, 0);
        @(posedge clk); #1;
        s_valid = 0;
        check("s_back_to_zero", s_out, 18'h0);
        check("s_r0_dec_valid", s_dec_valid, 1);
        check("s_r0_dec_data", s_dec, 18'h3FFFF);
        @(posedge clk); #1;
        check("s_r0_dec_valid2", s_dec_valid, 1);
        check("s_r0_dec_data2", s_dec, 18'h0);
        @(posedge clk); #1;
        check("s_dec_valid_drop", s_dec_valid, 0);

        // Decimation by 4, then ratio 4->2 while cnt=3
        dq_cyc.delete();
        dq_data.delete();
        @(posedge clk); #1;
        w8_valid = 1; w8_data = 8'd1;
        c0 = cyc;
        for (int i = 1; i <= 22; i++) begin
            @(posedge clk); #1;
            if (i == 16) w8_ratio = 8'd2;
        end
        w8_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        check("dec_count", dq_cyc.size(), 7);
        for (int i = 0; i < 7 && i < dq_cyc.size(); i++) begin
            check("dec_cycle", dq_cyc[i] - c0, exp_off[i]);
            check("dec_data", dq_data[i], exp_dat[i]);
        end
        check("dec_hold", w8_dec, 8'd22);
        check("dec_valid_idle", w8_dec_valid, 0);

        // clr with in_valid=1 mid-stream: sample dropped, restart from 1
        for (int i = 0; i < 10; i++) step_o3(1, 9'd1, 0, 0);
        step_o3(1, 9'd1, 1, 0);
        step_o3(1, 9'd1, 0, 0);
        obs_q.delete();
        check("clr_data_out", o3_out, 0);
        check("clr_out_valid", o3_out_valid, 0);
        check("clr_dec_data", o3_dec, 0);
        check("clr_dec_valid", o3_dec_valid, 0);
        for (int i = 0; i < 4; i++) step_o3(1, 9'd1, 0, 0);
        step_o3(0, 9'd0, 0, 0);
        drain_o3();
        check_seq("clr_restart_seq", seq5, 5);

        // rst_n pulsed mid-stream: in-flight samples discarded
        for (int i = 0; i < 6; i++) step_o3(1, 9'd1, 0, 0);
        step_o3(1, 9'd1, 0, 1);
        step_o3(0, 9'd0, 0, 0);
        obs_q.delete();
        check("rst_mid_data_out", o3_out, 0);
        check("rst_mid_out_valid", o3_out_valid, 0);
        check("rst_mid_dec_data", o3_dec, 0);
        check("rst_mid_dec_valid", o3_dec_valid, 0);
        for (int i = 0; i < 4; i++) step_o3(0, 9'd0, 0, 0);
        check("rst_mid_no_output", obs_q.size(), 0);
        for (int i = 0; i < 5; i++) step_o3(1, 9'd1, 0, 0);
        step_o3(0, 9'd0, 0, 0);
        drain_o3();
        check_seq("rst_restart_seq", seq5, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_integrator_cascade.md
CIC_INTEGRATOR_CASCADE -- requirements
Module: cic_integrator_cascade

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 9: input sample width.
REQ-002 SHALL have parameter WIDTH_OUT, default 18: accumulator and output width, WIDTH_OUT >= WIDTH_IN.
REQ-003 SHALL have parameter ORDER, default 3: number of cascaded integrator stages, legal range 1..6.
REQ-004 SHALL have parameter SIGNED_IN, default 0: 0 zero-extends data_in, 1 sign-extends data_in.
REQ-005 SHALL have parameter RATIO_W, default 8: width of the decimation ratio input.
REQ-006 SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port clr, input, 1 bit: synchronous flush of all datapath state.
REQ-009 SHALL have port in_valid, input, 1 bit: data_in qualifier.
REQ-010 SHALL have port data_in, input, WIDTH_IN bits: input sample.
REQ-011 SHALL have port ratio, input, RATIO_W bits: decimation factor R.
REQ-012 SHALL have port data_out, output, WIDTH_OUT bits: last-stage accumulator.
REQ-013 SHALL have port out_valid, output, 1 bit: data_out updated this cycle.
REQ-014 SHALL have port dec_data, output, WIDTH_OUT bits: decimated sample.
REQ-015 SHALL have port dec_valid, output, 1 bit: one-cycle strobe qualifying dec_data.

Function
REQ-016 Stage 1 SHALL add the extended data_in to acc[1] on each edge where in_valid=1, and SHALL hold when in_valid=0.
REQ-017 Stage k (2..ORDER) SHALL add acc[k-1] to acc[k] on each edge where v[k-1]=1, where v[1] is in_valid registered and v[k] is v[k-1] registered.
REQ-018 data_out SHALL equal acc[ORDER]; out_valid SHALL equal v[ORDER], asserted exactly ORDER cycles after the in_valid cycle.
REQ-019 Each valid input SHALL produce exactly one out_valid pulse; gaps in in_valid SHALL propagate as gaps, with no state change in the held stages.
REQ-020 All additions SHALL be modulo 2^WIDTH_OUT with no saturation and no overflow flag; wrap is required for correct CIC operation.
REQ-021 A decimation counter cnt (RATIO_W bits) SHALL count out_valid pulses.
REQ-022 On out_valid with cnt >= R-1, the block SHALL set dec_data <= data_out and dec_valid <= 1, and SHALL set cnt <= 0 on that edge.
REQ-023 On out_valid with cnt < R-1, the block SHALL set cnt <= cnt+1; dec_valid SHALL be 0 on every cycle not covered by REQ-022.
REQ-024 R=0 and R=1 SHALL both decimate by 1, giving dec_valid one cycle after every out_valid.
REQ-025 A ratio change mid-run SHALL take effect at the next comparison, with no reset of cnt; the >= compare guarantees a fire when R shrinks below cnt+1.
REQ-026 dec_data SHALL hold its value between strobes.
REQ-027 When clr=1, on that edge all acc, v, cnt, dec_data and dec_valid SHALL go to 0, and in_valid on the same cycle SHALL be discarded.
REQ-028 The block SHALL have no backpressure: throughput is 1 sample per cycle at any duty cycle.

Reset
REQ-029 With rst_n=0 at a rising edge, the block SHALL clear all acc, v, cnt, dec_data and dec_valid to 0, so data_out=0, out_valid=0, dec_data=0, dec_valid=0.
REQ-030 rst_n SHALL have priority over clr and in_valid.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight samples, with no out_valid after release until new input arrives.

Verification
REQ-032 ORDER=3, in_valid=1 and data_in=1 continuous from reset release -> out_valid first high 3 cycles after first input, data_out sequence 1, 4, 10, 20, 35.
REQ-033 ORDER=1, WIDTH_OUT=8, WIDTH_IN=8, inputs 255 then 255 -> data_out 255 then 254 (wrap).
REQ-034 SIGNED_IN=1, ORDER=1, WIDTH_IN=9, WIDTH_OUT=18, single input 9'h1FF -> data_out 18'h3FFFF; a following input 9'h001 -> data_out 0.
REQ-035 ORDER=1, ratio=4, data_in=1 continuous -> dec_valid every 4th cycle with dec_data 4, 8, 12; ratio switched 4->2 while cnt=3 -> immediate fire on next out_valid, then period 2.
REQ-036 ORDER=3, in_valid toggling 1,0,1,0 with data_in=1 -> out_valid toggles identically, delayed 3 cycles, data_out 1, 4, 10 on valid cycles.
REQ-037 clr pulsed with in_valid=1 after 10 samples, and separately rst_n pulsed mid-stream -> all outputs 0 on the next cycle, that sample dropped, and the sequence restarts from 1.
